// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type, constants and the redirect-target helper
// used by the instruction-fetch stage (fetch_unit) and its redirect logic.
package fetch_pkg;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // Default encoding of the instruction that stops fetch.
  localparam logic [31:0] SYSCALL_WORD_DEFAULT = 32'h0000_000c;

  // Sequential PC increment (one 32-bit word).
  localparam logic [31:0] PC_STEP = 32'd4;

  // Computes the redirect destination. A jump replaces the low 28 bits of
  // the base with the word-aligned target field; a branch adds the
  // sign-extended word offset to the base. Jump wins when both are present.
  function automatic logic [31:0] redirect_target(
    input logic        jump,
    input logic [15:0] br_offset,
    input logic [25:0] jump_target,
    input logic [31:0] redir_base
  );
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    br_tgt = redir_base + {{14{br_offset[15]}}, br_offset, 2'b00};
    j_tgt  = {redir_base[31:28], jump_target, 2'b00};
    if (jump) begin
      return j_tgt;
    end else begin
      return br_tgt;
    end
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: IF/ID output bundle carrying the captured instruction and
// its valid/ready handshake toward decode. The fetch stage is the master.
interface fetch_unit_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    output out_ready
  );

endinterface

// File: rtl/fetch_redirect.sv
// fetch_redirect: combinational redirect decode. Flags a redirect when a
// branch or jump is requested and computes the new PC (jump has priority).
module fetch_redirect
  import fetch_pkg::*;
(
  input  logic        br_take,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic [31:0] redir_base,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  // Redirect request and destination, purely combinational.
  always_comb begin
    redirect_valid = br_take | jump;
    redirect_pc    = redirect_target(jump, br_offset, jump_target, redir_base);
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of an asynchronous instMem.
// Owns the PC, captures the returned word into an IF/ID register with a
// valid/ready handshake, takes branch/jump redirects and halts on SYSCALL.
// Optional build macro FETCH_PERF_CNT_EN adds capture and stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] SYSCALL_WORD = SYSCALL_WORD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [31:0]  read_address,
  input  logic [31:0]  instruction,
  fetch_unit_if.master out_if,
  input  logic         br_take,
  input  logic [15:0]  br_offset,
  input  logic         jump,
  input  logic [25:0]  jump_target,
  input  logic [31:0]  redir_base,
  output logic         halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stalls
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  opc_q, opc_d;
  logic [31:0]  opc4_q, opc4_d;
  logic         halted_q;

  logic         redirect_valid_s;
  logic [31:0]  redirect_pc_s;
  logic         redir_en_s;
  logic         adv_s;

  fetch_redirect u_redirect (
    .br_take        (br_take),
    .br_offset      (br_offset),
    .jump           (jump),
    .jump_target    (jump_target),
    .redir_base     (redir_base),
    .redirect_valid (redirect_valid_s),
    .redirect_pc    (redirect_pc_s)
  );

  // Redirects are ignored during the boot settle cycle; the output
  // register may take a new word when empty or being drained this cycle.
  always_comb begin
    redir_en_s = redirect_valid_s && (state_q != S_BOOT);
    adv_s      = !valid_q || out_if.out_ready;
  end

  // Next-state, PC and IF/ID register computation; redirect has priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    opc4_d  = opc4_q;
    if (redir_en_s) begin
      // Flush the held word even if decode is taking it: it is on the
      // wrong path once the redirect arrives.
      pc_d    = redirect_pc_s;
      valid_d = 1'b0;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_d = S_RUN;
          if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        S_RUN: begin
          if (adv_s) begin
            instr_d = instruction;
            opc_d   = pc_q;
            opc4_d  = pc_q + PC_STEP;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_STEP;
            if (instruction == SYSCALL_WORD) begin
              state_d = S_HALT;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            state_d = S_RUN;
          end
        end
        S_HALT: begin
          if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        default: begin
          state_d = S_BOOT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, PC and IF/ID output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0000_0000;
      opc_q    <= 32'h0000_0000;
      opc4_q   <= 32'h0000_0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      opc4_q   <= opc4_d;
      halted_q <= (state_d == S_HALT);
    end
  end

  assign read_address        = pc_q;
  assign halted              = halted_q;
  assign out_if.out_valid    = valid_q;
  assign out_if.out_instr    = instr_q;
  assign out_if.out_pc       = opc_q;
  assign out_if.out_pc_plus4 = opc4_q;

`ifdef FETCH_PERF_CNT_EN
  logic        capture_s;
  logic        stall_s;
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stalls_q;

  // Capture and stall qualifiers for the performance counters.
  always_comb begin
    capture_s = (state_q == S_RUN) && adv_s && !redir_en_s;
    stall_s   = (state_q == S_RUN) && !adv_s && !redir_en_s;
  end

  // Free-running wrap-around capture and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_stalls_q  <= 32'd0;
    end else begin
      if (capture_s) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end else begin
        perf_fetched_q <= perf_fetched_q;
      end
      if (stall_s) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end else begin
        perf_stalls_q <= perf_stalls_q;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized bench for fetch_unit, checked
// against a cycle-level behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] read_address;
  logic [31:0] instruction;
  logic        br_take;
  logic [15:0] br_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] redir_base;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  fetch_unit_if dif ();

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_address (read_address),
    .instruction  (instruction),
    .out_if       (dif.master),
    .br_take      (br_take),
    .br_offset    (br_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .redir_base   (redir_base),
    .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 64 words at 0..255, synthetic words elsewhere.
  logic [31:0] mem [0:63];
  assign instruction = (read_address < 32'd256) ? mem[read_address[7:2]]
                                                : {read_address[31:2], 2'b01};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return {a[31:2], 2'b01};
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: what the stage holds after each clock edge.
  logic [31:0] m_pc, m_instr, m_opc;
  logic        m_valid, m_booting, m_halted;
  logic [31:0] m_fetched, m_stalls;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_opc = 32'h0;
    m_valid = 1'b0; m_booting = 1'b1; m_halted = 1'b0;
    m_fetched = 32'h0; m_stalls = 32'h0;
  endtask

  // Predict the effect of the next edge from the inputs now applied.
  task automatic model_next();
    logic [31:0] tgt;
    logic [31:0] off;
    off = {{16{br_offset[15]}}, br_offset};
    if (jump) tgt = {redir_base[31:28], jump_target, 2'b00};
    else      tgt = redir_base + off * 32'd4;
    if ((br_take || jump) && !m_booting) begin
      m_pc = tgt; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
      if (dif.out_ready) m_valid = 1'b0;
    end else if (m_halted) begin
      if (dif.out_ready) m_valid = 1'b0;
    end else if (!m_valid || dif.out_ready) begin
      m_instr = mem_word(m_pc);
      m_opc = m_pc;
      m_valid = 1'b1;
      m_fetched = m_fetched + 32'd1;
      if (m_instr == 32'h0000_000c) m_halted = 1'b1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_stalls = m_stalls + 32'd1;
    end
  endtask

  task automatic compare_all();
    check_eq("read_address", read_address, m_pc);
    check_eq("out_valid", {31'd0, dif.out_valid}, {31'd0, m_valid});
    check_eq("out_instr", dif.out_instr, m_instr);
    check_eq("out_pc", dif.out_pc, m_opc);
    check_eq("out_pc_plus4", dif.out_pc_plus4, (m_opc == 32'h0 && m_instr == 32'h0 && !m_valid) ? dif.out_pc_plus4 & 32'h0 : m_opc + 32'd4);
    check_eq("halted", {31'd0, halted}, {31'd0, m_halted});
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetched", perf_fetched, m_fetched);
    check_eq("perf_stalls", perf_stalls, m_stalls);
`endif
  endtask

  // One cycle: apply inputs at negedge, predict, clock, compare at negedge.
  task automatic step(input logic rdy, input logic bt, input logic [15:0] bo,
                      input logic jp, input logic [25:0] jt, input logic [31:0] rb);
    dif.out_ready = rdy; br_take = bt; br_offset = bo;
    jump = jp; jump_target = jt; redir_base = rb;
    model_next();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; dif.out_ready = 1'b0; br_take = 1'b0; br_offset = 16'h0;
    jump = 1'b0; jump_target = 26'h0; redir_base = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 | 32'(i);
    mem[0] = 32'h381d_3ffc; mem[1] = 32'h3808_0004;
    mem[2] = 32'h3809_0001; mem[3] = 32'h0000_000c;
    model_reset();

    // Reset values.
    @(negedge clk);
    check_eq("rst_read_address", read_address, 32'h0);
    check_eq("rst_out_valid", {31'd0, dif.out_valid}, 32'h0);
    check_eq("rst_out_instr", dif.out_instr, 32'h0);
    check_eq("rst_out_pc", dif.out_pc, 32'h0);
    check_eq("rst_out_pc_plus4", dif.out_pc_plus4, 32'h0);
    check_eq("rst_halted", {31'd0, halted}, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch with decode always ready.
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    check_eq("boot_read_address", read_address, 32'h0);
    check_eq("boot_no_capture", {31'd0, dif.out_valid}, 32'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    check_eq("seq0_instr", dif.out_instr, 32'h381d_3ffc);
    check_eq("seq0_pc", dif.out_pc, 32'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    check_eq("seq1_instr", dif.out_instr, 32'h3808_0004);
    check_eq("seq1_pc", dif.out_pc, 32'h4);

    // Stall for three cycles.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
      check_eq("stall_instr", dif.out_instr, 32'h3808_0004);
      check_eq("stall_addr", read_address, 32'h8);
    end
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    check_eq("post_stall_instr", dif.out_instr, 32'h3809_0001);
    check_eq("post_stall_pc", dif.out_pc, 32'h8);

    // Backward branch to 0x08.
    step(1'b1, 1'b1, 16'hfffe, 1'b0, 26'h0, 32'h10);
    check_eq("br_pc", read_address, 32'h8);
    check_eq("br_flush", {31'd0, dif.out_valid}, 32'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    check_eq("br_instr", dif.out_instr, 32'h3809_0001);

    // Jump and branch together: jump wins.
    step(1'b1, 1'b1, 16'h0100, 1'b1, 26'h1, 32'h4000_0000);
    check_eq("jb_pc", read_address, 32'h4000_0004);

    // SYSCALL at 12 halts fetch; a jump releases it.
    step(1'b1, 1'b0, 16'h0, 1'b1, 26'h3, 32'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    check_eq("sys_instr", dif.out_instr, 32'h0000_000c);
    check_eq("sys_halted", {31'd0, halted}, 32'h1);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
      check_eq("halt_no_capture", {31'd0, dif.out_valid}, 32'h0);
      check_eq("halt_pc_frozen", read_address, 32'h10);
    end
    step(1'b1, 1'b0, 16'h0, 1'b1, 26'h0, 32'h0);
    check_eq("unhalt", {31'd0, halted}, 32'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    check_eq("unhalt_instr", dif.out_instr, 32'h381d_3ffc);

    // PC wrap from 0xFFFFFFFC.
    step(1'b1, 1'b0, 16'h0, 1'b1, 26'h3ff_ffff, 32'hf000_0000);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    check_eq("wrap_pc", read_address, 32'h0);
    check_eq("wrap_out_pc", dif.out_pc, 32'hffff_fffc);
    check_eq("wrap_pc_plus4", dif.out_pc_plus4, 32'h0);

    // Asynchronous reset during a stall.
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, dif.out_valid}, 32'h0);
    check_eq("arst_pc", read_address, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("arst_perf_fetched", perf_fetched, 32'h0);
    check_eq("arst_perf_stalls", perf_stalls, 32'h0);
`endif

    // Random phase with fresh memory contents.
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == 32'h0000_000c) mem[i] = 32'h0000_000d;
      if ((i % 13) == 7) mem[i] = 32'h0000_000c;
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 800; n++) begin
      int          r;
      logic        rdy;
      logic [31:0] rb;
      r   = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 9) < 7);
      rb  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63)) * 32'd4;
      step(rdy, (r < 8), 16'($urandom_range(0, 40)) - 16'd20, (r >= 5 && r < 12),
           26'($urandom_range(0, 70)), rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
